ram_controller: RTL and testbench



---
 rtl/ram_pkg.sv | 25 ++
 rtl/ram_if.sv | 30 +++
 rtl/ram_array.sv | 41 ++++
 rtl/ram_controller.sv | 151 +++++++++++++++
 tb/tb_ram_controller.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_pkg
// Description : Shared types and constants for the ram_controller slice:
//               controller state encoding, the out-of-range read pattern and
//               the wait-counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_pkg;

    // Controller states, fixed 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    // Word returned for reads outside the populated address range.
    localparam logic [31:0] RAM_BAD_READ = 32'hDEADBEEF;

    // Wide enough for LATENCY-1 over the legal LATENCY range 1..15.
    localparam int LATENCY_W = 4;

endpackage
`default_nettype wire

// File: rtl/ram_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_if
// Description : Request/acknowledge bus between the ALU memory port (master)
//               and the RAM controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_if;

    logic [31:0] ramAddress;
    logic [31:0] ramOut;
    logic        readReq;
    logic        writeReq;
    logic [31:0] ramIn;
    logic        readAck;
    logic        writeAck;
    logic        accessErr;

    modport master (
        output ramAddress, ramOut, readReq, writeReq,
        input  ramIn, readAck, writeAck, accessErr
    );

    modport slave (
        input  ramAddress, ramOut, readReq, writeReq,
        output ramIn, readAck, writeAck, accessErr
    );

endinterface
`default_nettype wire

// File: rtl/ram_array.sv
`default_nettype none
// ============================================================================
// Module      : ram_array
// Description : Synchronous single-port 32-bit word array. Writes land on the
//               clock edge while we is high; reads are registered and only
//               update rdata when re is high, so rdata holds the last word
//               read. Array contents are never reset, only rdata is.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_array #(
    parameter int DEPTH_LOG2 = 10
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  re,
    input  wire logic                  we,
    input  wire logic [DEPTH_LOG2-1:0] index,
    input  wire logic [31:0]           wdata,
    output logic      [31:0]           rdata
);

    logic [31:0] r_mem [0:(1 << DEPTH_LOG2) - 1];

    // Storage write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[index] <= wdata;
        end
    end

    // Registered read port; holds its value between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= 32'h0;
        end else if (re) begin
            rdata <= r_mem[index];
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_controller.sv
`default_nettype none
// ============================================================================
// Module      : ram_controller
// Description : Word-addressed on-chip RAM behind a request/acknowledge front
//               end. A sampled read or write request is latched, held for
//               LATENCY wait cycles, then completed with a one-cycle ack.
//               Optional feature macro: RAM_BOUNDS_CHECK_EN enables
//               out-of-range detection (bad-read pattern, dropped writes and
//               a sticky accessErr flag); without it addresses wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_controller
    import ram_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 1
) (
    input  wire logic clk,
    input  wire logic reset,
    ram_if.slave      bus
);

    localparam logic [LATENCY_W-1:0] c_COUNT_LOAD = LATENCY_W'(LATENCY - 1);

    state_t                r_state;
    logic [LATENCY_W-1:0]  r_count;
    logic [DEPTH_LOG2-1:0] r_index;
    logic [31:0]           r_wdata;
    logic                  r_isWrite;
    logic                  r_readAck;
    logic                  r_writeAck;

    logic                  w_lastWait;
    logic                  w_re;
    logic                  w_we;
    logic                  w_wordOk;
    logic [31:0]           w_rdata;

    // The array read is launched on the final wait cycle so its registered
    // output is valid throughout ACK.
    assign w_lastWait = (r_state == WAIT) && (r_count == '0);
    assign w_re       = w_lastWait && !r_isWrite;

`ifdef RAM_BOUNDS_CHECK_EN
    logic r_outOfRange;
    logic r_badRead;
    logic r_accessErr;
    logic w_reqOutOfRange;
    logic w_unusedAddrBits;

    assign w_reqOutOfRange  = |bus.ramAddress[31:DEPTH_LOG2+2];
    assign w_unusedAddrBits = ^bus.ramAddress[1:0];
    assign w_wordOk         = !r_outOfRange;
    assign bus.ramIn        = r_badRead ? RAM_BAD_READ : w_rdata;
    assign bus.accessErr    = r_accessErr;

    // Out-of-range tracking: flag latched per request, bad-read select
    // updated only on reads, error flag sticky until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outOfRange <= 1'b0;
            r_badRead    <= 1'b0;
            r_accessErr  <= 1'b0;
        end else begin
            if ((r_state == IDLE) && (bus.readReq || bus.writeReq)) begin
                r_outOfRange <= w_reqOutOfRange;
            end
            if (w_lastWait) begin
                if (!r_isWrite) begin
                    r_badRead <= r_outOfRange;
                end
                if (r_outOfRange) begin
                    r_accessErr <= 1'b1;
                end
            end
        end
    end
`else
    logic w_unusedAddrBits;

    // Upper address bits are ignored, so accesses wrap modulo the RAM size.
    assign w_unusedAddrBits = ^{bus.ramAddress[31:DEPTH_LOG2+2], bus.ramAddress[1:0]};
    assign w_wordOk         = 1'b1;
    assign bus.ramIn        = w_rdata;
    assign bus.accessErr    = 1'b0;
`endif

    // Writes commit on the edge leaving ACK; an async reset forces IDLE and
    // therefore discards a pending write.
    assign w_we = (r_state == ACK) && r_isWrite && w_wordOk;

    assign bus.readAck  = r_readAck;
    assign bus.writeAck = r_writeAck;

    // Request/wait/acknowledge sequencer with registered acknowledges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_index    <= '0;
            r_wdata    <= 32'h0;
            r_isWrite  <= 1'b0;
            r_readAck  <= 1'b0;
            r_writeAck <= 1'b0;
        end else begin
            r_readAck  <= 1'b0;
            r_writeAck <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.readReq || bus.writeReq) begin
                        r_index   <= bus.ramAddress[DEPTH_LOG2+1:2];
                        r_wdata   <= bus.ramOut;
                        // A simultaneous read is dropped in favour of the write.
                        r_isWrite <= bus.writeReq;
                        r_count   <= c_COUNT_LOAD;
                        r_state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_count == '0) begin
                        r_readAck  <= !r_isWrite;
                        r_writeAck <= r_isWrite;
                        r_state    <= ACK;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                ACK: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    ram_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .rst   (reset),
        .re    (w_re),
        .we    (w_we),
        .index (r_index),
        .wdata (r_wdata),
        .rdata (w_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_ram_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_controller
// Description : Scoreboard bench for ram_controller. Two instances run side by
//               side: dut A with LATENCY=1 and dut B with LATENCY=4. Requests
//               push the expected acknowledge (cycle, kind, data, error flag)
//               into a per-instance queue; a monitor pops and compares on
//               every acknowledge pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_controller;

`ifdef RAM_BOUNDS_CHECK_EN
    localparam bit c_BC = 1'b1;
`else
    localparam bit c_BC = 1'b0;
`endif

    typedef struct {
        int unsigned cyc;
        bit          isWrite;
        logic [31:0] data;
        bit          err;
    } exp_t;

    logic clk;
    logic resetA;
    logic resetB;
    int unsigned cyc;
    int passed;
    int total;
    exp_t q0[$];
    exp_t q1[$];

    ram_if ifA ();
    ram_if ifB ();

    ram_controller #(.DEPTH_LOG2(10), .LATENCY(1)) u_dutA (
        .clk   (clk),
        .reset (resetA),
        .bus   (ifA.slave)
    );

    ram_controller #(.DEPTH_LOG2(10), .LATENCY(4)) u_dutB (
        .clk   (clk),
        .reset (resetB),
        .bus   (ifB.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle index: value seen during a cycle equals the posedges so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic mon(input int d, input logic rA, input logic wA,
                       input logic [31:0] rin, input logic err);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (rA || wA) begin
            chk(d == 0 ? "A_dual_ack" : "B_dual_ack", {31'h0, rA & wA}, 32'h0);
            if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            if (!have) begin
                chk(d == 0 ? "A_unexpected_ack" : "B_unexpected_ack", 32'h1, 32'h0);
            end else begin
                chk(d == 0 ? "A_ack_cycle" : "B_ack_cycle", cyc, e.cyc);
                chk(d == 0 ? "A_ack_kind" : "B_ack_kind", {31'h0, wA}, {31'h0, e.isWrite});
                if (!e.isWrite) chk(d == 0 ? "A_ramIn" : "B_ramIn", rin, e.data);
                chk(d == 0 ? "A_accessErr" : "B_accessErr", {31'h0, err}, {31'h0, e.err});
            end
        end
    endtask

    // Monitor: compare every acknowledge away from the active edge.
    always @(negedge clk) begin
        mon(0, ifA.readAck, ifA.writeAck, ifA.ramIn, ifA.accessErr);
        mon(1, ifB.readAck, ifB.writeAck, ifB.ramIn, ifB.accessErr);
    end

    task automatic drive(input int d, input bit rd, input bit wr,
                         input logic [31:0] addr, input logic [31:0] data);
        if (d == 0) begin
            ifA.readReq = rd; ifA.writeReq = wr; ifA.ramAddress = addr; ifA.ramOut = data;
        end else begin
            ifB.readReq = rd; ifB.writeReq = wr; ifB.ramAddress = addr; ifB.ramOut = data;
        end
    endtask

    task automatic push(input int d, input int unsigned ackCyc, input bit w,
                        input logic [31:0] data, input bit err);
        exp_t e;
        e.cyc = ackCyc; e.isWrite = w; e.data = data; e.err = err;
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // One request pulse, expectation pushed, then wait until back in IDLE.
    task automatic issue(input int d, input bit rd, input bit wr,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] expRead, input bit expErr);
        int lat;
        lat = (d == 0) ? 1 : 4;
        @(posedge clk); #1;
        drive(d, rd, wr, addr, data);
        push(d, cyc + lat + 1, wr, wr ? 32'h0 : expRead, expErr);
        @(posedge clk); #1;
        drive(d, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (lat + 1) @(posedge clk);
    endtask

    initial begin
        cyc = 0; passed = 0; total = 0;
        resetA = 1'b1; resetB = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1 resetA = 1'b0; resetB = 1'b0;
        @(negedge clk);
        chk("A_rst_ramIn", ifA.ramIn, 32'h0);
        chk("A_rst_readAck", {31'h0, ifA.readAck}, 32'h0);
        chk("A_rst_writeAck", {31'h0, ifA.writeAck}, 32'h0);
        chk("A_rst_accessErr", {31'h0, ifA.accessErr}, 32'h0);
        chk("B_rst_ramIn", ifB.ramIn, 32'h0);
        chk("B_rst_readAck", {31'h0, ifB.readAck}, 32'h0);
        chk("B_rst_writeAck", {31'h0, ifB.writeAck}, 32'h0);
        chk("B_rst_accessErr", {31'h0, ifB.accessErr}, 32'h0);

        // dut A, LATENCY=1: write then read back.
        issue(0, 0, 1, 32'h10, 32'h12345678, 32'h0, 0);
        issue(0, 1, 0, 32'h10, 32'h0, 32'h12345678, 0);
        // Simultaneous read+write: only the write is acknowledged.
        issue(0, 1, 1, 32'h20, 32'hCAFEF00D, 32'h0, 0);
        @(negedge clk);
        chk("A_ramIn_hold_after_write", ifA.ramIn, 32'h12345678);
        issue(0, 1, 0, 32'h20, 32'h0, 32'hCAFEF00D, 0);
        // Overwrite a just-read address: new value is returned.
        issue(0, 0, 1, 32'h10, 32'hFEEDFACE, 32'h0, 0);
        issue(0, 1, 0, 32'h10, 32'h0, 32'hFEEDFACE, 0);
        // Preload then fetch pattern 0x0, 0x4 with one-cycle requests.
        issue(0, 0, 1, 32'h0, 32'h00C0FFEE, 32'h0, 0);
        issue(0, 0, 1, 32'h4, 32'h13579BDF, 32'h0, 0);
        issue(0, 1, 0, 32'h0, 32'h0, 32'h00C0FFEE, 0);
        issue(0, 1, 0, 32'h4, 32'h0, 32'h13579BDF, 0);
        // Address 0x1000: wraps to word 0, or bad read with sticky error.
        issue(0, 1, 0, 32'h1000, 32'h0, c_BC ? 32'hDEADBEEF : 32'h00C0FFEE, c_BC);
        issue(0, 1, 0, 32'h4, 32'h0, 32'h13579BDF, c_BC);
        @(negedge clk);
        chk("A_accessErr_sticky", {31'h0, ifA.accessErr}, {31'h0, c_BC});

        // dut B, LATENCY=4: preload.
        issue(1, 0, 1, 32'h08, 32'h11110008, 32'h0, 0);
        issue(1, 0, 1, 32'h10, 32'h0BADF00D, 32'h0, 0);
        // Read with an extra pulse during WAIT: single ack at t+5.
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b0, 32'h10, 32'h0);
        push(1, cyc + 5, 1'b0, 32'h0BADF00D, 1'b0);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b0, 32'h08, 32'h0);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (4) @(posedge clk);
        // Write 0x55 to 0x08 aborted by reset during WAIT: no ack expected.
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b1, 32'h08, 32'h55);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        resetB = 1'b1;
        @(posedge clk); #1;
        resetB = 1'b0;
        @(negedge clk);
        chk("B_abort_ramIn", ifB.ramIn, 32'h0);
        chk("B_abort_writeAck", {31'h0, ifB.writeAck}, 32'h0);
        repeat (8) @(posedge clk);
        issue(1, 1, 0, 32'h08, 32'h0, 32'h11110008, 0);

        repeat (4) @(posedge clk);
        chk("A_queue_drained", 32'(q0.size()), 32'h0);
        chk("B_queue_drained", 32'(q1.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
